// File: rtl/p2s_pkg.sv
// -----------------------------------------------------------------------------
// p2s_pkg
//   Shared constants and types for the P2S transmit scheduler slice.
//   WORD_W / PAYLOAD_W : serializer word width and payload width
//   HDR_DATA / HDR_IDLE: 2-bit word headers for data and idle words
//   CH_IDX_W           : width of a channel index (up to 8 channels)
//   state_t            : scheduler FSM states
// -----------------------------------------------------------------------------
package p2s_pkg;

    localparam int WORD_W    = 16;
    localparam int PAYLOAD_W = 14;
    localparam int CH_IDX_W  = 3;

    localparam logic [1:0] HDR_DATA = 2'b11;
    localparam logic [1:0] HDR_IDLE = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/p2s_rr_arbiter.sv
// -----------------------------------------------------------------------------
// p2s_rr_arbiter
//   Purely combinational round-robin pick. The winner is the lowest requesting
//   index at or above rr_ptr_i; if none, the lowest requesting index below it.
//   Ports:
//     req_i       in  NUM_CH    request vector
//     rr_ptr_i    in  3         first index with priority
//     grant_o     out NUM_CH    one-hot grant (all zero when nobody requests)
//     grant_idx_o out 3         binary index of the grant
//     any_grant_o out 1         at least one request present
// -----------------------------------------------------------------------------
module p2s_rr_arbiter
    import p2s_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]   req_i,
    input  logic [CH_IDX_W-1:0] rr_ptr_i,
    output logic [NUM_CH-1:0]   grant_o,
    output logic [CH_IDX_W-1:0] grant_idx_o,
    output logic                any_grant_o
);

    logic                found;
    logic [CH_IDX_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // First pass: indices at or above the pointer.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_i[i] && (i >= int'(rr_ptr_i))) begin
                found = 1'b1;
                idx   = CH_IDX_W'(i);
            end
        end
        // Second pass wraps around; anything found here lies below the pointer.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx   = CH_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            grant_o[i] = found && (idx == CH_IDX_W'(i));
        end
        grant_idx_o = idx;
        any_grant_o = found;
    end

endmodule

// File: rtl/p2s_tx_scheduler.sv
// -----------------------------------------------------------------------------
// p2s_tx_scheduler
//   Shares the 16-bit P2S serializer between NUM_CH word requesters. Granted
//   14-bit payloads are framed as {2'b11, payload} and held on word_out for 16
//   clk cycles (one per serialized bit). Between frames word_out is an idle
//   word (header 2'b00). Optional GAP_CYCLES idle cycles follow every frame.
//
//   Handshake: a requester raises req_valid[i] with req_data[i] stable and
//   keeps both until req_ready[i] is seen high. req_ready is a combinational
//   one-hot pulse; the payload is taken at the clock edge that ends the cycle
//   in which req_ready is high. Dropping req_valid before that is allowed.
//
//   Ports:
//     clk          in  1            serializer bit clock (ps_clk)
//     rst          in  1            asynchronous, active-high reset
//     req_valid    in  NUM_CH       payload pending per requester
//     req_data     in  NUM_CH*14    payload i at bits [14*i+13:14*i]
//     req_ready    out NUM_CH       one-hot accept pulse
//     word_out     out 16           word to serializer din
//     word_valid   out 1            word_out carries a data header
//     bit_idx      out 4            bit the serializer emits this cycle
//     frame_start  out 1            first cycle of each frame
//     active_ch    out 3            channel owning the current frame
//     busy         out 1            FSM not in IDLE
//     dbg_state    out state_t      FSM state, for observation
// -----------------------------------------------------------------------------
module p2s_tx_scheduler
    import p2s_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   req_data,
    output logic [NUM_CH-1:0]             req_ready,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    output logic [3:0]                    bit_idx,
    output logic                          frame_start,
    output logic [CH_IDX_W-1:0]           active_ch,
    output logic                          busy,
    output state_t                        dbg_state
);

    localparam logic       GAP_EN   = (GAP_CYCLES != 0);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [WORD_W-1:0] IDLE_WORD = {HDR_IDLE, {PAYLOAD_W{1'b0}}};

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  word_valid_q, word_valid_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic                  frame_start_q, frame_start_d;
    logic [CH_IDX_W-1:0]   active_ch_q, active_ch_d;
    logic [CH_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;

    logic [NUM_CH-1:0]     grant;
    logic [CH_IDX_W-1:0]   grant_idx;
    logic                  any_grant;
    logic [PAYLOAD_W-1:0]  grant_payload;
    logic [CH_IDX_W-1:0]   rr_next;
    logic                  eval_grant;
    logic                  accept;

    p2s_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_IDX_W'(i)) begin
                grant_payload = req_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign rr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_IDX_W'(1);

    // Arbitration happens in IDLE, and on the last bit of a frame only when
    // back-to-back framing is allowed (no gap configured).
    assign eval_grant = (state_q == IDLE) ||
                        ((state_q == SHIFT) && (bit_idx_q == 4'd15) && !GAP_EN);
    assign accept     = eval_grant && any_grant;
    assign req_ready  = accept ? grant : '0;

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        bit_idx_d     = bit_idx_q;
        frame_start_d = 1'b0;
        active_ch_d   = active_ch_q;
        rr_ptr_d      = rr_ptr_q;
        gap_cnt_d     = gap_cnt_q;

        if (accept) begin
            state_d       = SHIFT;
            word_d        = {HDR_DATA, grant_payload};
            bit_idx_d     = 4'd0;
            frame_start_d = 1'b1;
            active_ch_d   = grant_idx;
            rr_ptr_d      = rr_next;
        end else begin
            case (state_q)
                IDLE: begin
                    word_d    = IDLE_WORD;
                    bit_idx_d = 4'd0;
                end
                SHIFT: begin
                    if (bit_idx_q == 4'd15) begin
                        word_d    = IDLE_WORD;
                        bit_idx_d = 4'd0;
                        if (GAP_EN) begin
                            state_d   = GAP;
                            gap_cnt_d = 4'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                GAP: begin
                    word_d = IDLE_WORD;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    word_d  = IDLE_WORD;
                end
            endcase
        end

        word_valid_d = (word_d[WORD_W-1 -: 2] == HDR_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            bit_idx_q     <= 4'd0;
            frame_start_q <= 1'b0;
            active_ch_q   <= '0;
            rr_ptr_q      <= '0;
            gap_cnt_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            bit_idx_q     <= bit_idx_d;
            frame_start_q <= frame_start_d;
            active_ch_q   <= active_ch_d;
            rr_ptr_q      <= rr_ptr_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign word_out    = word_q;
    assign word_valid  = word_valid_q;
    assign bit_idx     = bit_idx_q;
    assign frame_start = frame_start_q;
    assign active_ch   = active_ch_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_p2s_tx_scheduler
//   Directed bench for p2s_tx_scheduler. dut0 runs with GAP_CYCLES=0, dut2
//   with GAP_CYCLES=2; both have four requesters and share one clock.
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_p2s_tx_scheduler;
    import p2s_pkg::*;

    localparam int NCH = 4;

    logic              clk;
    logic              rst0, rst2;
    logic [NCH-1:0]    v0, v2;
    logic [NCH*14-1:0] d0, d2;

    logic [NCH-1:0] rdy0, rdy2;
    logic [15:0]    word0, word2;
    logic           wv0, wv2;
    logic [3:0]     bi0, bi2;
    logic           fs0, fs2;
    logic [2:0]     ac0, ac2;
    logic           busy0, busy2;
    state_t         st0, st2;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    p2s_tx_scheduler #(.NUM_CH(NCH), .GAP_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst0), .req_valid (v0), .req_data (d0),
        .req_ready (rdy0), .word_out (word0), .word_valid (wv0),
        .bit_idx (bi0), .frame_start (fs0), .active_ch (ac0),
        .busy (busy0), .dbg_state (st0)
    );

    p2s_tx_scheduler #(.NUM_CH(NCH), .GAP_CYCLES(2)) dut2 (
        .clk (clk), .rst (rst2), .req_valid (v2), .req_data (d2),
        .req_ready (rdy2), .word_out (word2), .word_valid (wv2),
        .bit_idx (bi2), .frame_start (fs2), .active_ch (ac2),
        .busy (busy2), .dbg_state (st2)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame0(input logic [15:0] w, input logic [2:0] ch, input int k);
        chk("d0_word", 32'(word0), 32'(w));
        chk("d0_word_valid", 32'(wv0), 32'd1);
        chk("d0_bit_idx", 32'(bi0), 32'(k));
        chk("d0_frame_start", 32'(fs0), (k == 0) ? 32'd1 : 32'd0);
        chk("d0_active_ch", 32'(ac0), 32'(ch));
        chk("d0_busy", 32'(busy0), 32'd1);
    endtask

    task automatic chk_idle0();
        chk("d0_idle_word", 32'(word0), 32'h0);
        chk("d0_idle_valid", 32'(wv0), 32'd0);
        chk("d0_idle_busy", 32'(busy0), 32'd0);
        chk("d0_idle_state", 32'(st0), 32'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst0 = 1'b1;
        rst2 = 1'b1;
        v0   = '0;
        v2   = '0;
        d0   = '0;
        d2   = '0;

        // Reset state
        step();
        step();
        chk("rst_word", 32'(word0), 32'h0);
        chk("rst_word_valid", 32'(wv0), 32'd0);
        chk("rst_bit_idx", 32'(bi0), 32'd0);
        chk("rst_frame_start", 32'(fs0), 32'd0);
        chk("rst_active_ch", 32'(ac0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_req_ready", 32'(rdy0), 32'd0);
        rst0 = 1'b0;
        rst2 = 1'b0;

        // No requests for 50 cycles on dut2
        for (int c = 0; c < 50; c++) begin
            step();
            chk("quiet_busy", 32'(busy2), 32'd0);
            chk("quiet_word", 32'(word2), 32'h0);
            chk("quiet_ready", 32'(rdy2), 32'd0);
        end

        // ch0, ch1, ch3 together, back-to-back frames in order 0,1,3
        d0[0*14 +: 14] = 14'h0AAA;
        d0[1*14 +: 14] = 14'h1555;
        d0[3*14 +: 14] = 14'h2F0F;
        v0 = 4'b1011;
        #1;
        chk("b2b_ready0", 32'(rdy0), 32'b0001);
        step();
        v0 = 4'b1010;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hCAAA, 3'd0, k);
            if (k < 15) begin
                chk("b2b_noready0", 32'(rdy0), 32'd0);
                step();
                #1;
            end
        end
        chk("b2b_ready1", 32'(rdy0), 32'b0010);
        step();
        v0 = 4'b1000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hD555, 3'd1, k);
            if (k < 15) begin
                step();
                #1;
            end
        end
        chk("b2b_ready3", 32'(rdy0), 32'b1000);
        step();
        v0 = 4'b0000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hEF0F, 3'd3, k);
            if (k < 15) begin
                step();
                #1;
            end
        end
        chk("b2b_last_noready", 32'(rdy0), 32'd0);
        step();
        #1;
        chk_idle0();

        // Single request from ch2 (pointer currently 0)
        d0[2*14 +: 14] = 14'h1ABC;
        v0 = 4'b0100;
        #1;
        chk("ch2_ready", 32'(rdy0), 32'b0100);
        step();
        v0 = 4'b0000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hDABC, 3'd2, k);
            step();
            #1;
        end
        chk_idle0();
        chk("ch2_after_ready", 32'(rdy0), 32'd0);

        // Pointer now 3: ch0 and ch3 pending -> ch3 first, then wrap to ch0
        d0[0*14 +: 14] = 14'h0011;
        d0[3*14 +: 14] = 14'h3333;
        v0 = 4'b1001;
        #1;
        chk("wrap_ready3", 32'(rdy0), 32'b1000);
        step();
        v0 = 4'b0001;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hF333, 3'd3, k);
            if (k < 15) begin
                step();
                #1;
            end
        end
        chk("wrap_ready0", 32'(rdy0), 32'b0001);
        step();
        v0 = 4'b0000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hC011, 3'd0, k);
            step();
            #1;
        end
        chk_idle0();

        // Reset at bit_idx 7 of a ch2 frame (pointer currently 1)
        d0[2*14 +: 14] = 14'h0123;
        v0 = 4'b0100;
        #1;
        chk("rst_mid_ready2", 32'(rdy0), 32'b0100);
        step();
        v0 = 4'b0000;
        #1;
        for (int k = 0; k < 7; k++) begin
            step();
        end
        #1;
        chk("rst_mid_bit7", 32'(bi0), 32'd7);
        chk("rst_mid_word", 32'(word0), 32'hC123);
        rst0 = 1'b1;
        #1;
        chk("rst_mid_word0", 32'(word0), 32'h0);
        chk("rst_mid_valid0", 32'(wv0), 32'd0);
        chk("rst_mid_bit0", 32'(bi0), 32'd0);
        chk("rst_mid_busy0", 32'(busy0), 32'd0);
        step();
        step();
        rst0 = 1'b0;
        // Pointer back at 0: ch1 wins over ch3
        d0[1*14 +: 14] = 14'h0777;
        d0[3*14 +: 14] = 14'h3FFF;
        v0 = 4'b1010;
        #1;
        chk("post_rst_ready1", 32'(rdy0), 32'b0010);
        step();
        v0 = 4'b1000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hC777, 3'd1, k);
            if (k < 15) begin
                step();
                #1;
            end
        end
        chk("post_rst_ready3", 32'(rdy0), 32'b1000);
        step();
        v0 = 4'b0000;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk_frame0(16'hFFFF, 3'd3, k);
            step();
            #1;
        end
        chk_idle0();

        // GAP_CYCLES=2 with ch1 continuously valid: period of 19 cycles
        d2[1*14 +: 14] = 14'h0246;
        v2 = 4'b0010;
        #1;
        chk("gap_first_ready", 32'(rdy2), 32'b0010);
        step();
        #1;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 19; c++) begin
                if (c < 16) begin
                    chk("gap_word", 32'(word2), 32'hC246);
                    chk("gap_valid", 32'(wv2), 32'd1);
                    chk("gap_bit_idx", 32'(bi2), 32'(c));
                    chk("gap_fs", 32'(fs2), (c == 0) ? 32'd1 : 32'd0);
                    chk("gap_active", 32'(ac2), 32'd1);
                    chk("gap_ready_shift", 32'(rdy2), 32'd0);
                end else if (c < 18) begin
                    chk("gap_idle_word", 32'(word2), 32'h0);
                    chk("gap_idle_valid", 32'(wv2), 32'd0);
                    chk("gap_state", 32'(st2), 32'(GAP));
                    chk("gap_busy", 32'(busy2), 32'd1);
                    chk("gap_ready_gap", 32'(rdy2), 32'd0);
                end else begin
                    chk("gap_idle_state", 32'(st2), 32'(IDLE));
                    chk("gap_idle_busy", 32'(busy2), 32'd0);
                    chk("gap_idle_wordz", 32'(word2), 32'h0);
                    chk("gap_idle_ready", 32'(rdy2), 32'b0010);
                end
                step();
                #1;
            end
        end
        chk("gap_third_frame", 32'(word2), 32'hC246);
        chk("gap_third_fs", 32'(fs2), 32'd1);
        v2 = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
